// File: rtl/pim_bitserial_pkg.sv
// Shared types and helpers for the bit-serial compare/select blocks.
package pim_bitserial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-index counter width for an operand of w bits.
  function automatic int idx_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/cmp_bit_step.sv
// One MSB-first decision cell: the first differing bit fixes the outcome,
// and every later bit passes the earlier decision through unchanged.
module cmp_bit_step (
  input  logic a_bit,
  input  logic b_bit,
  input  logic decided_in,
  input  logic gt_in,
  output logic decided_out,
  output logic gt_out
);

  // Latch the decision on the first difference; A wins iff its bit is the 1.
  always_comb begin
    decided_out = decided_in | (a_bit ^ b_bit);
    gt_out      = decided_in ? gt_in : (a_bit & ~b_bit);
  end

endmodule

// File: rtl/max_uint_bitserial.sv
// Unsigned max of two operands, compared one bit per clock from MSB to LSB.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for an operand pair, in_ready=1
//   CMP   | walking idx down from WIDTH-1, one bit per clock
//   DONE  | result presented with out_valid=1 until out_ready
module max_uint_bitserial
  import pim_bitserial_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             gt
);

  localparam int IW = idx_width(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, b_r;
  logic [IW-1:0]    idx;
  logic             decided, gt_r;
  logic             decided_nx, gt_nx;
  logic             decide_now, cmp_exit;

  cmp_bit_step u_step (
    .a_bit       (a_r[idx]),
    .b_bit       (b_r[idx]),
    .decided_in  (decided),
    .gt_in       (gt_r),
    .decided_out (decided_nx),
    .gt_out      (gt_nx)
  );

  // Leave CMP after the LSB, or as soon as the outcome is fixed in early-exit mode.
  always_comb begin
    decide_now = decided_nx & ~decided;
    cmp_exit   = (idx == '0) || (EARLY_EXIT && decide_now);
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = CMP;
      end
      CMP: begin
        if (cmp_exit) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register, operand capture, bit-index down-counter and decision flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      idx     <= IW'(WIDTH - 1);
      decided <= 1'b0;
      gt_r    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r     <= A;
            b_r     <= B;
            idx     <= IW'(WIDTH - 1);
            decided <= 1'b0;
            gt_r    <= 1'b0;
          end
        end
        CMP: begin
          decided <= decided_nx;
          gt_r    <= gt_nx;
          if (!cmp_exit) idx <= idx - IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Result mux; outputs read zero outside DONE so a discarded result never leaks.
  always_comb begin
    Y  = (state == DONE) ? (gt_r ? a_r : b_r) : '0;
    gt = (state == DONE) & gt_r;
  end

endmodule
